// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction info in, ALU-operand mux selects and stall out, for the
// forwarding / load-use hazard controller.
interface fwd_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, flush,
    input  fwd_a_sel, fwd_b_sel, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, flush,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadows EX/MEM destination info,
// registers the operand-mux selects and raises a same-cycle load-use stall.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  fwd_hazard_ctrl_if.slave bus
);

  // Encoding follows the physical mux port order; 2'b11 floats the mux.
  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10
  } sel_e;

  logic             ex_valid, ex_wr, ex_ld;
  logic [REG_W-1:0] ex_dest;
  logic             mem_valid, mem_wr;
  logic [REG_W-1:0] mem_dest;

  sel_e             a_sel, b_sel;
  sel_e             a_next, b_next;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  logic ex_fwd_ok, mem_fwd_ok, take_id;

  assign ex_fwd_ok  = ex_valid && ex_wr && (ex_dest != '0);
  assign mem_fwd_ok = mem_valid && mem_wr && (mem_dest != '0);

  assign stall = ex_fwd_ok && ex_ld && bus.id_valid && !bus.flush &&
                 ((bus.id_uses_rs && bus.id_rs == ex_dest) ||
                  (bus.id_uses_rt && bus.id_rt == ex_dest));

  assign take_id = bus.id_valid && !bus.flush && !stall;

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    a_next = SEL_RF;
    b_next = SEL_RF;
    if (bus.id_uses_rs && ex_fwd_ok && ex_dest == bus.id_rs)
      a_next = SEL_EXMEM;
    else if (bus.id_uses_rs && mem_fwd_ok && mem_dest == bus.id_rs)
      a_next = SEL_MEMWB;
    if (bus.id_uses_rt && ex_fwd_ok && ex_dest == bus.id_rt)
      b_next = SEL_EXMEM;
    else if (bus.id_uses_rt && mem_fwd_ok && mem_dest == bus.id_rt)
      b_next = SEL_MEMWB;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_wr       <= 1'b0;
      ex_ld       <= 1'b0;
      ex_dest     <= '0;
      mem_valid   <= 1'b0;
      mem_wr      <= 1'b0;
      mem_dest    <= '0;
      a_sel       <= SEL_RF;
      b_sel       <= SEL_RF;
      stall_count <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_dest  <= ex_dest;

      if (take_id) begin
        ex_valid <= 1'b1;
        ex_wr    <= bus.id_reg_write;
        ex_ld    <= bus.id_mem_read;
        ex_dest  <= bus.id_dest;
        a_sel    <= a_next;
        b_sel    <= b_next;
      end else begin
        ex_valid <= 1'b0;
        ex_wr    <= 1'b0;
        ex_ld    <= 1'b0;
        ex_dest  <= '0;
        a_sel    <= SEL_RF;
        b_sel    <= SEL_RF;
      end

      if (stall && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

  assign bus.fwd_a_sel   = a_sel;
  assign bus.fwd_b_sel   = b_sel;
  assign bus.stall       = stall;
  assign bus.stall_count = stall_count;

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the pipelined MIPS core.
- Keeps a shadow copy of the destination-register info for the EX and MEM stages.
- Drives the 2-bit select inputs of the two 3x1 ALU-operand muxes (operand A and operand B) with registered selects.
- Raises a stall that freezes IF/ID and injects a bubble when a load result is needed too early. Counts stall cycles for debug.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_W  source register A of the ID instruction.
- id_rt  input  REG_W  source register B of the ID instruction.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_dest  input  REG_W  destination register of the ID instruction (rd or rt already resolved).
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  kill the ID instruction (branch/jump taken).
- fwd_a_sel  output  2  select for the operand-A mux, valid for the instruction in EX.
- fwd_b_sel  output  2  select for the operand-B mux, valid for the instruction in EX.
- stall  output  1  hold PC and IF/ID this cycle; combinational.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset is asynchronous: all shadow-stage valid bits 0, all dest fields 0, fwd_a_sel = fwd_b_sel = 2'b00, stall_count = 0. stall = 0 because EX is empty.
- Select encoding, fixed to the mux port order:
  - 00 = register-file value.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB write-back value.
  - 11 is never driven; the mux outputs Z on 11, so driving it is a design error.
- Shadow state:
  - EX stage: ex_valid, ex_dest, ex_wr, ex_ld.
  - MEM stage: mem_valid, mem_dest, mem_wr.
- stall (combinational) = ex_valid & ex_ld & ex_wr & (ex_dest != 0) & id_valid & !flush & ((id_uses_rs & id_rs == ex_dest) | (id_uses_rt & id_rt == ex_dest)).
- Every rising edge, the MEM stage is loaded from the current EX stage unconditionally; there are no back-end stalls.
- EX-stage update:
  - If flush, stall, or !id_valid: EX gets a bubble (ex_valid = 0) and both selects get 00.
  - Otherwise EX is loaded from the id_* inputs and each select is computed from the pre-edge EX and MEM entries. For operand A (B identical with rt / id_uses_rt):
    - 01 if ex_valid & ex_wr & ex_dest != 0 & id_uses_rs & ex_dest == id_rs.
    - else 10 if mem_valid & mem_wr & mem_dest != 0 & id_uses_rs & mem_dest == id_rs.
    - else 00.
- Priority: the newer producer (EX/MEM) beats the older one (MEM/WB) when both match.
- Register $0 is never forwarded or stalled on.
- A load in EX can never produce select 01, because that case stalls first. After one bubble, the load sits in MEM and is selected with 10.
- Hazards three or more stages apart are covered by the write-first register file; this block does not track the WB stage.
- Latency:
  - Selects are registered and appear in the cycle the instruction occupies EX.
  - stall is same-cycle.
  - A load-use hazard costs exactly 1 stall cycle, with no repeat stall after the bubble.
- flush has priority over stall: when flush is 1, stall is 0 and a bubble enters EX.
- stall_count increments on each edge where stall = 1 and saturates at all-ones.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge; in-flight entries are discarded.

Test Plan:
- Reset: assert reset while selects are nonzero -> selects 00, stall 0, stall_count 0 with no clock edge; after release with id_valid = 0 for 3 cycles -> selects stay 00.
- EX/MEM forward: ADD $3 (dest 3, reg_write), then SUB rs = 3, rt = 4 -> in SUB's EX cycle fwd_a_sel = 01, fwd_b_sel = 00.
- MEM/WB forward and priority:
  - dest 5, then an unrelated instruction, then rs = 5 -> fwd_a_sel = 10.
  - dest 5, dest 5, then rt = 5 -> fwd_b_sel = 01 (newer producer wins).
- Load-use: LW dest 7, then ADD rs = 7, rt = 7 -> stall = 1 for exactly 1 cycle, then in ADD's EX cycle both selects = 10; stall_count = 1.
- $0 and flush:
  - dest 0 producer, then rs = 0 -> select 00.
  - LW dest 8, then rs = 8 with flush = 1 -> stall = 0, next EX is a bubble, selects 00.
- Counter saturation: CNT_W = 4, repeat 20 load-use pairs -> stall_count stops at 15.
